uart_receiver: RTL and testbench

Parametrised UART receive engine replacing the fixed 8N1, 4x-oversampled receiver on the calculator's serial input path. Supports configurable data width, parity, stop-bit count and oversampling ratio, majority-vote bit sampling and false-start rejection. Received words are held under a valid/ack handshake with parity, framing and overrun status, so the command parser can consume them at its own pace.

---
 rtl/uart_receiver.sv | 186 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Parametrised UART receive engine: oversampled majority-vote bit recovery,
// optional parity, 1 or 2 stop bits, and valid/ack delivery with error status.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_PRE   = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_MID   = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_DEC   = SMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                 state_r;
  logic [1:0]             sync_r;
  logic [DIV_W-1:0]       div_cnt_r;
  logic [SMP_W-1:0]       smp_cnt_r;
  logic [3:0]             bit_cnt_r;
  logic                   smp_a_r;
  logic                   smp_b_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_pend_r;
  logic                   frm_pend_r;

  logic rxd_s;
  logic tick_s;
  logic vote_s;
  logic decide_s;
  logic bit_end_s;
  logic exp_par_s;

  assign rxd_s     = sync_r[1];
  assign tick_s    = (div_cnt_r == DIV_LAST);
  assign vote_s    = majority3(smp_a_r, smp_b_r, rxd_s);
  assign decide_s  = tick_s && (smp_cnt_r == SMP_DEC);
  assign bit_end_s = tick_s && (smp_cnt_r == SMP_LAST);
  assign exp_par_s = parity_of(shift_r, PAR_ODD);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Frame FSM with sample capture and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      smp_cnt_r  <= '0;
      bit_cnt_r  <= 4'd0;
      smp_a_r    <= 1'b0;
      smp_b_r    <= 1'b0;
      shift_r    <= '0;
      par_pend_r <= 1'b0;
      frm_pend_r <= 1'b0;
      data       <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (tick_s && (state_r != ST_IDLE)) begin
        smp_cnt_r <= (smp_cnt_r == SMP_LAST) ? '0 : smp_cnt_r + SMP_W'(1);
        if (smp_cnt_r == SMP_PRE) smp_a_r <= rxd_s;
        if (smp_cnt_r == SMP_MID) smp_b_r <= rxd_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (tick_s && !rxd_s) begin
            smp_cnt_r  <= '0;
            bit_cnt_r  <= 4'd0;
            par_pend_r <= 1'b0;
            frm_pend_r <= 1'b0;
            busy       <= 1'b1;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (decide_s && vote_s) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (bit_end_s) begin
            bit_cnt_r <= 4'd0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide_s) shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
          if (bit_end_s) begin
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= 4'd0;
              state_r   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (decide_s) par_pend_r <= (vote_s != exp_par_s);
          if (bit_end_s) state_r <= ST_STOP;
        end
        ST_STOP: begin
          // Deliver at the last stop decision so the next start edge is not missed
          if (decide_s) begin
            if (bit_cnt_r == STOP_LAST) begin
              data       <= shift_r;
              parity_err <= par_pend_r;
              frame_err  <= frm_pend_r | ~vote_s;
              overrun    <= rx_valid & ~rx_ack;
              rx_valid   <= 1'b1;
              busy       <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              frm_pend_r <= frm_pend_r | ~vote_s;
            end
          end else if (bit_end_s) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench: three receiver configurations driven from a vector table plus
// hand-written sequences for false start, overrun and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_FREQ = 614_400;
  localparam int BAUD     = 9_600;
  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BIT      = OS * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] rxd_v;
  logic [2:0] ack_v;
  logic [2:0] valid_v;
  logic [2:0] pe_v;
  logic [2:0] fe_v;
  logic [2:0] ov_v;
  logic [2:0] busy_v;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[0]), .rx_ack(ack_v[0]), .data(d0),
    .rx_valid(valid_v[0]), .parity_err(pe_v[0]), .frame_err(fe_v[0]),
    .overrun(ov_v[0]), .busy(busy_v[0]));

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[1]), .rx_ack(ack_v[1]), .data(d1),
    .rx_valid(valid_v[1]), .parity_err(pe_v[1]), .frame_err(fe_v[1]),
    .overrun(ov_v[1]), .busy(busy_v[1]));

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_v[2]), .rx_ack(ack_v[2]), .data(d2),
    .rx_valid(valid_v[2]), .parity_err(pe_v[2]), .frame_err(fe_v[2]),
    .overrun(ov_v[2]), .busy(busy_v[2]));

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       use_par;
    logic       par_bit;
    logic       stop_bit;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [8:0] dat_of(input int ch);
    case (ch)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b00, d2};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd,
                                             input logic use_par, input logic par_bit,
                                             input logic [1:0] stops, input int ns);
    logic [15:0] f;
    int k;
    f = 16'hFFFF;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin f[k] = d[i]; k++; end
    if (use_par) begin f[k] = par_bit; k++; end
    for (int i = 0; i < ns; i++) begin f[k] = stops[i]; k++; end
    return f;
  endfunction

  task automatic drive(input int ch, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_v[ch] = f[i];
      repeat (BIT) @(negedge clk);
    end
    rxd_v[ch] = 1'b1;
  endtask

  task automatic check_frame(input int ch, input string tag, input logic [8:0] exp_d,
                             input logic pe, input logic fe, input logic ov);
    check({tag, ".valid"}, 16'(valid_v[ch]), 16'h1);
    check({tag, ".data"}, 16'(dat_of(ch)), 16'(exp_d));
    check({tag, ".parity_err"}, 16'(pe_v[ch]), 16'(pe));
    check({tag, ".frame_err"}, 16'(fe_v[ch]), 16'(fe));
    check({tag, ".overrun"}, 16'(ov_v[ch]), 16'(ov));
  endtask

  task automatic ack(input int ch, input string tag);
    ack_v[ch] = 1'b1;
    @(negedge clk);
    ack_v[ch] = 1'b0;
    check({tag, ".ack_valid"}, 16'(valid_v[ch]), 16'h0);
    check({tag, ".ack_overrun"}, 16'(ov_v[ch]), 16'h0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] f;
    //            ch  data    par  pbit stop  exp_d  pe    fe
    vecs[0] = '{0, 9'h055, 1'b0, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h0A3, 1'b1, 1'b1, 1'b1, 9'h0A3, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h0A3, 1'b1, 1'b0, 1'b1, 9'h0A3, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h03C, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1};
    vecs[4] = '{0, 9'h081, 1'b0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h007, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};

    reset_n = 1'b0;
    rxd_v   = 3'b111;
    ack_v   = 3'b000;
    repeat (5) @(negedge clk);
    check("reset.data0", 16'(d0), 16'h0);
    check("reset.valid", 16'(valid_v), 16'h0);
    check("reset.busy", 16'(busy_v), 16'h0);
    check("reset.flags", {7'd0, pe_v, fe_v, ov_v}, 16'h0);
    reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      f = frame_bits(vecs[v].d, 8, vecs[v].use_par, vecs[v].par_bit,
                     {1'b1, vecs[v].stop_bit}, 1);
      drive(vecs[v].ch, f, vecs[v].use_par ? 11 : 10);
      repeat (BIT) @(negedge clk);
      check_frame(vecs[v].ch, $sformatf("vec%0d", v), vecs[v].exp_d,
                  vecs[v].exp_pe, vecs[v].exp_fe, 1'b0);
      ack(vecs[v].ch, $sformatf("vec%0d", v));
      repeat (BIT) @(negedge clk);
    end

    // False start: line low for three ticks only
    rxd_v[0] = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rxd_v[0] = 1'b1;
    check("false_start.busy_high", 16'(busy_v[0]), 16'h1);
    repeat (BIT) @(negedge clk);
    check("false_start.busy_low", 16'(busy_v[0]), 16'h0);
    check("false_start.no_valid", 16'(valid_v[0]), 16'h0);
    drive(0, frame_bits(9'h042, 8, 1'b0, 1'b0, 2'b11, 1), 10);
    repeat (BIT) @(negedge clk);
    check_frame(0, "after_false", 9'h042, 1'b0, 1'b0, 1'b0);
    ack(0, "after_false");
    repeat (BIT) @(negedge clk);

    // Overrun: two frames without an acknowledge
    drive(0, frame_bits(9'h011, 8, 1'b0, 1'b0, 2'b11, 1), 10);
    repeat (BIT) @(negedge clk);
    check_frame(0, "ovr1", 9'h011, 1'b0, 1'b0, 1'b0);
    drive(0, frame_bits(9'h022, 8, 1'b0, 1'b0, 2'b11, 1), 10);
    repeat (BIT) @(negedge clk);
    check_frame(0, "ovr2", 9'h022, 1'b0, 1'b0, 1'b1);
    ack(0, "ovr2");

    // Seven data bits, two stop bits
    drive(2, frame_bits(9'h07F, 7, 1'b0, 1'b0, 2'b11, 2), 10);
    repeat (BIT) @(negedge clk);
    check_frame(2, "d7s2", 9'h07F, 1'b0, 1'b0, 1'b0);
    ack(2, "d7s2");
    drive(2, frame_bits(9'h02A, 7, 1'b0, 1'b0, 2'b01, 2), 10);
    repeat (2 * BIT) @(negedge clk);
    check_frame(2, "d7s2_stop2bad", 9'h02A, 1'b0, 1'b1, 1'b0);

    // Reset asserted in the middle of data bit 3
    f = frame_bits(9'h005, 7, 1'b0, 1'b0, 2'b11, 2);
    drive(2, f, 4);
    rxd_v[2] = f[4];
    repeat (BIT / 2) @(negedge clk);
    check("midreset.busy_before", 16'(busy_v[2]), 16'h1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset.data", 16'(d2), 16'h0);
    check("midreset.valid", 16'(valid_v), 16'h0);
    check("midreset.busy", 16'(busy_v), 16'h0);
    check("midreset.frame_err", 16'(fe_v), 16'h0);
    rxd_v[2] = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    drive(2, f, 10);
    repeat (BIT) @(negedge clk);
    check_frame(2, "post_reset", 9'h005, 1'b0, 1'b0, 1'b0);
    ack(2, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
